// File: rtl/calc_sequencer_if.sv
// rtl/calc_sequencer_if.sv - bus between calc_sequencer, its host and the calculadora datapath (div_err only with CALC_SEQ_DIV0_GUARD_EN)
interface calc_sequencer_if;
    logic       start;
    logic [2:0] a_in;
    logic [2:0] b_in;
    logic [5:0] result;
    logic [2:0] A;
    logic [2:0] B;
    logic [1:0] sel;
    logic       busy;
    logic       done;
    logic [5:0] sum_r;
    logic [5:0] sub_r;
    logic [5:0] prod_r;
    logic [2:0] quo_r;
    logic [2:0] rem_r;
`ifdef CALC_SEQ_DIV0_GUARD_EN
    logic       div_err;

    // host + calculadora side
    modport master (
        output start, a_in, b_in, result,
        input  A, B, sel, busy, done, sum_r, sub_r, prod_r, quo_r, rem_r, div_err
    );

    // sequencer side
    modport slave (
        input  start, a_in, b_in, result,
        output A, B, sel, busy, done, sum_r, sub_r, prod_r, quo_r, rem_r, div_err
    );
`else
    // host + calculadora side
    modport master (
        output start, a_in, b_in, result,
        input  A, B, sel, busy, done, sum_r, sub_r, prod_r, quo_r, rem_r
    );

    // sequencer side
    modport slave (
        input  start, a_in, b_in, result,
        output A, B, sel, busy, done, sum_r, sub_r, prod_r, quo_r, rem_r
    );
`endif
endinterface

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - steps calculadora through sum/sub/prod/div and captures each result; optional divide-by-zero skip via CALC_SEQ_DIV0_GUARD_EN
module calc_sequencer #(
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    calc_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

    state_t     state;
    logic [3:0] cnt;

    // Sequencer FSM: all outputs are registered here so the calculadora sees stable A/B/sel
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            bus.A      <= 3'd0;
            bus.B      <= 3'd0;
            bus.sel    <= 2'b00;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.sum_r  <= 6'd0;
            bus.sub_r  <= 6'd0;
            bus.prod_r <= 6'd0;
            bus.quo_r  <= 3'd0;
            bus.rem_r  <= 3'd0;
`ifdef CALC_SEQ_DIV0_GUARD_EN
            bus.div_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        bus.A    <= bus.a_in;
                        bus.B    <= bus.b_in;
                        bus.sel  <= 2'b00;
                        cnt      <= 4'd0;
                        bus.busy <= 1'b1;
`ifdef CALC_SEQ_DIV0_GUARD_EN
                        bus.div_err <= 1'b0;
`endif
                        state    <= RUN;
                    end
                end

                RUN: begin
                    if (cnt == CNT_LAST) begin
                        // Selector has settled: capture and move to the next operation
                        cnt <= 4'd0;
                        case (bus.sel)
                            2'b00: begin
                                bus.sum_r <= bus.result;
                                bus.sel   <= 2'b01;
                            end
                            2'b01: begin
                                bus.sub_r <= bus.result;
                                bus.sel   <= 2'b10;
                            end
                            2'b10: begin
                                bus.prod_r <= bus.result;
`ifdef CALC_SEQ_DIV0_GUARD_EN
                                if (bus.B == 3'd0) begin
                                    // Division by zero never reaches the calculadora
                                    bus.quo_r   <= 3'd0;
                                    bus.rem_r   <= 3'd0;
                                    bus.div_err <= 1'b1;
                                    bus.busy    <= 1'b0;
                                    bus.done    <= 1'b1;
                                    state       <= DONE;
                                end else begin
                                    bus.sel <= 2'b11;
                                end
`else
                                bus.sel <= 2'b11;
`endif
                            end
                            default: begin
                                bus.quo_r <= bus.result[2:0];
                                bus.rem_r <= bus.result[5:3];
                                bus.sel   <= 2'b00;
                                bus.busy  <= 1'b0;
                                bus.done  <= 1'b1;
                                state     <= DONE;
                            end
                        endcase
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                DONE: begin
                    bus.done <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed self-checking bench for calc_sequencer at SETTLE=1 and SETTLE=3
module tb_calc_sequencer;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    calc_sequencer_if bus1 ();
    calc_sequencer_if bus3 ();

    calc_sequencer #(.SETTLE(1)) u1 (.clk(clk), .rst(rst), .bus(bus1));
    calc_sequencer #(.SETTLE(3)) u3 (.clk(clk), .rst(rst), .bus(bus3));

    // Behavioural calculadora: quotient in [2:0], remainder in [5:3]; B=0 gives quo=7, rem=A
    function automatic logic [5:0] calc(input logic [2:0] a, input logic [2:0] b, input logic [1:0] s);
        logic [5:0] r;
        case (s)
            2'b00:   r = 6'(a) + 6'(b);
            2'b01:   r = 6'(a) - 6'(b);
            2'b10:   r = 6'(a) * 6'(b);
            default: r = (b == 3'd0) ? {a, 3'b111} : {3'(a % b), 3'(a / b)};
        endcase
        return r;
    endfunction

    assign bus1.result = calc(bus1.A, bus1.B, bus1.sel);
    assign bus3.result = calc(bus3.A, bus3.B, bus3.sel);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done on the SETTLE=1 instance; reports latency, busy cycles and whether sel=11 was seen
    task automatic wait_done1(output int lat, output int busyc, output int sel3);
        lat = 0;
        busyc = 0;
        sel3 = 0;
        while (bus1.done !== 1'b1 && lat < 20) begin
            if (bus1.busy === 1'b1) busyc++;
            if (bus1.sel === 2'b11) sel3++;
            tick();
            lat++;
        end
    endtask

    int lat, busyc, sel3, dcount;

    initial begin
        rst = 1'b1;
        bus1.start = 1'b0; bus1.a_in = 3'd0; bus1.b_in = 3'd0;
        bus3.start = 1'b0; bus3.a_in = 3'd0; bus3.b_in = 3'd0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_busy", 32'(bus1.busy), 0);
        chk("rst_done", 32'(bus1.done), 0);
        chk("rst_sel", 32'(bus1.sel), 0);
        chk("rst_A", 32'(bus1.A), 0);
        chk("rst_sum", 32'(bus1.sum_r), 0);

        // SETTLE=1, 6 and 7
        bus1.a_in = 3'd6; bus1.b_in = 3'd7; bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        chk("acc_busy", 32'(bus1.busy), 1);
        chk("acc_A", 32'(bus1.A), 6);
        chk("acc_B", 32'(bus1.B), 7);
        chk("acc_sel", 32'(bus1.sel), 0);
        wait_done1(lat, busyc, sel3);
        chk("r1_latency", 32'(lat), 4);
        chk("r1_busy_cycles", 32'(busyc), 4);
        chk("r1_sum", 32'(bus1.sum_r), 13);
        chk("r1_sub", 32'(bus1.sub_r), 63);
        chk("r1_prod", 32'(bus1.prod_r), 42);
        chk("r1_quo", 32'(bus1.quo_r), 0);
        chk("r1_rem", 32'(bus1.rem_r), 6);
        tick();
        chk("r1_done_pulse_end", 32'(bus1.done), 0);
        chk("r1_A_hold", 32'(bus1.A), 6);

        // SETTLE=3, 5 and 2: each selector held 3 cycles
        bus3.a_in = 3'd5; bus3.b_in = 3'd2; bus3.start = 1'b1;
        tick();
        bus3.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("s3_sel_%0d", i), 32'(bus3.sel), 32'(i / 3));
            if (i == 11) chk("s3_no_early_done", 32'(bus3.done), 0);
            tick();
        end
        chk("s3_done_at_12", 32'(bus3.done), 1);
        chk("s3_sum", 32'(bus3.sum_r), 7);
        chk("s3_sub", 32'(bus3.sub_r), 3);
        chk("s3_prod", 32'(bus3.prod_r), 10);
        chk("s3_quo", 32'(bus3.quo_r), 2);
        chk("s3_rem", 32'(bus3.rem_r), 1);

        // start held high, a_in changed mid-run
        bus1.a_in = 3'd2; bus1.b_in = 3'd3; bus1.start = 1'b1;
        tick();
        bus1.a_in = 3'd3;
        tick();
        chk("hold_A_mid", 32'(bus1.A), 2);
        wait_done1(lat, busyc, sel3);
        chk("hold_latency", 32'(lat + 1), 4);
        chk("hold_A_done", 32'(bus1.A), 2);
        chk("hold_sum", 32'(bus1.sum_r), 5);
        chk("hold_rem", 32'(bus1.rem_r), 2);
        tick();
        chk("hold_idle_busy", 32'(bus1.busy), 0);
        chk("hold_idle_A", 32'(bus1.A), 2);
        tick();
        bus1.start = 1'b0;
        chk("hold_reaccept_busy", 32'(bus1.busy), 1);
        chk("hold_reaccept_A", 32'(bus1.A), 3);
        chk("hold_keep_sum", 32'(bus1.sum_r), 5);
        wait_done1(lat, busyc, sel3);
        chk("r2_latency", 32'(lat), 4);
        chk("r2_sum", 32'(bus1.sum_r), 6);
        chk("r2_sub", 32'(bus1.sub_r), 0);
        chk("r2_prod", 32'(bus1.prod_r), 9);
        chk("r2_quo", 32'(bus1.quo_r), 1);
        chk("r2_rem", 32'(bus1.rem_r), 0);
        tick();

        // Reset two cycles into a run, asserted together with start
        bus1.a_in = 3'd6; bus1.b_in = 3'd7; bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        bus1.start = 1'b1;
        tick();
        rst = 1'b0;
        bus1.start = 1'b0;
        chk("abort_busy", 32'(bus1.busy), 0);
        chk("abort_sel", 32'(bus1.sel), 0);
        chk("abort_A", 32'(bus1.A), 0);
        chk("abort_results", 32'({bus1.sum_r, bus1.sub_r, bus1.prod_r, bus1.quo_r, bus1.rem_r}), 0);
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus1.done === 1'b1) dcount++;
            tick();
        end
        chk("abort_no_done", 32'(dcount), 0);
        chk("abort_stays_idle", 32'(bus1.busy), 0);

        // B=0 division
        bus1.a_in = 3'd4; bus1.b_in = 3'd0; bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
        wait_done1(lat, busyc, sel3);
        chk("dz_sum", 32'(bus1.sum_r), 4);
        chk("dz_sub", 32'(bus1.sub_r), 4);
        chk("dz_prod", 32'(bus1.prod_r), 0);
`ifdef CALC_SEQ_DIV0_GUARD_EN
        chk("dz_latency", 32'(lat), 3);
        chk("dz_sel3_seen", 32'(sel3), 0);
        chk("dz_quo", 32'(bus1.quo_r), 0);
        chk("dz_rem", 32'(bus1.rem_r), 0);
        chk("dz_div_err", 32'(bus1.div_err), 1);
        tick();
        tick();
        chk("dz_div_err_hold", 32'(bus1.div_err), 1);
`else
        chk("dz_latency", 32'(lat), 4);
        chk("dz_sel3_seen", 32'(sel3), 1);
        chk("dz_quo", 32'(bus1.quo_r), 7);
        chk("dz_rem", 32'(bus1.rem_r), 4);
        tick();
        tick();
`endif

        // Following normal division run
        bus1.a_in = 3'd4; bus1.b_in = 3'd1; bus1.start = 1'b1;
        tick();
        bus1.start = 1'b0;
`ifdef CALC_SEQ_DIV0_GUARD_EN
        chk("nz_div_err_clr", 32'(bus1.div_err), 0);
`endif
        wait_done1(lat, busyc, sel3);
        chk("nz_latency", 32'(lat), 4);
        chk("nz_quo", 32'(bus1.quo_r), 4);
        chk("nz_rem", 32'(bus1.rem_r), 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
